// File: rtl/vga_sync_gen.sv
// 640x480 @ 60 Hz VGA timing generator: free-running h/v counters with a registered decode.
// Optional frame_tick output is built only when VGA_FRAME_TICK_EN is defined.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clock25,
    input  logic       reset_n,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y
`ifdef VGA_FRAME_TICK_EN
    ,
    output logic       frame_tick
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] h_count_q, h_count_d;
    logic [9:0] v_count_q, v_count_d;

    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_on_q, video_on_d;
    logic [9:0] pixel_x_q, pixel_x_d;
    logic [9:0] pixel_y_q, pixel_y_d;

    always_comb begin
        h_count_d = h_count_q + 10'd1;
        v_count_d = v_count_q;
        if (h_count_q == H_LAST) begin
            h_count_d = 10'd0;
            if (v_count_q == V_LAST) begin
                v_count_d = 10'd0;
            end else begin
                v_count_d = v_count_q + 10'd1;
            end
        end
    end

    // Decode the pre-edge counter value; the output flops add the single cycle of latency.
    always_comb begin
        video_on_d = (h_count_q < H_ACT) && (v_count_q < V_ACT);
        hsync_d    = !((h_count_q >= HS_START) && (h_count_q < HS_END));
        vsync_d    = !((v_count_q >= VS_START) && (v_count_q < VS_END));
        pixel_x_d  = h_count_q;
        pixel_y_d  = v_count_q;
    end

    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            h_count_q  <= 10'd0;
            v_count_q  <= 10'd0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b0;
            pixel_x_q  <= 10'd0;
            pixel_y_q  <= 10'd0;
        end else begin
            h_count_q  <= h_count_d;
            v_count_q  <= v_count_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
            pixel_x_q  <= pixel_x_d;
            pixel_y_q  <= pixel_y_d;
        end
    end

    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign video_on = video_on_q;
    assign pixel_x  = pixel_x_q;
    assign pixel_y  = pixel_y_q;

`ifdef VGA_FRAME_TICK_EN
    logic frame_tick_q, frame_tick_d;

    // Marks the first pixel of vertical blank so game logic can update off-screen.
    always_comb begin
        frame_tick_d = (h_count_q == 10'd0) && (v_count_q == V_ACT);
    end

    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= frame_tick_d;
        end
    end

    assign frame_tick = frame_tick_q;
`endif

endmodule
